// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and constants for the UART command-frame controller
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 6;

  typedef enum logic [$clog2(FRAME_LEN)-1:0] {
    ST_HUNT,
    ST_OP,
    ST_ADDR,
    ST_DHI,
    ST_DLO,
    ST_CHK
  } frame_state_e;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// rtl/uart_frame_ctrl_if.sv - byte stream in, command out and error reporting of the frame controller
interface uart_frame_ctrl_if;

  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_err;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;

  logic        err_chk;
  logic        err_frame;
  logic        err_timeout;
  logic        err_overrun;
  logic [7:0]  err_cnt;
  logic        err_clr;

  modport slave (
    input  rx_data, rx_done, rx_err, cmd_ready, err_clr,
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    output err_chk, err_frame, err_timeout, err_overrun, err_cnt
  );

  modport master (
    output rx_data, rx_done, rx_err, cmd_ready, err_clr,
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  err_chk, err_frame, err_timeout, err_overrun, err_cnt
  );

endinterface

// File: rtl/frame_timeout.sv
// rtl/frame_timeout.sv - inter-byte gap watchdog: reload on clr, count down while run
module frame_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic anrst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int             CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // A clear in the terminal cycle means a byte arrived in time, so it masks expiry.
  assign expire = run && !clr && (cnt_q == '0);

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - sync hunt, frame collection, XOR check and command handoff behind uart_rx
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int  CLK_HZ         = 200_000_000,
  parameter int  BAUD           = 9600,
  parameter int  TIMEOUT_BYTES  = 4,
  localparam int TIMEOUT_CYCLES = CLK_HZ / BAUD * 10 * TIMEOUT_BYTES
) (
  input logic              clk,
  input logic              anrst,
  uart_frame_ctrl_if.slave frm_if
);

  frame_state_e state_q, state_d;
  logic [7:0]   op_q, op_d;
  logic [7:0]   addr_q, addr_d;
  logic [7:0]   dhi_q, dhi_d;
  logic [7:0]   dlo_q, dlo_d;
  logic [7:0]   xor_q, xor_d;
  cmd_t         cmd_q, cmd_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic         err_chk_q, err_chk_d;
  logic         err_frame_q, err_frame_d;
  logic         err_timeout_q, err_timeout_d;
  logic         err_overrun_q, err_overrun_d;
  logic [7:0]   err_cnt_q, err_cnt_d;

  logic byte_ok;
  logic slot_free;
  logic expire;

  assign byte_ok   = frm_if.rx_done && !frm_if.rx_err;
  assign slot_free = !cmd_valid_q || frm_if.cmd_ready;

  frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .anrst  (anrst),
    .clr    (byte_ok),
    .run    (state_q != ST_HUNT),
    .expire (expire)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    dhi_d         = dhi_q;
    dlo_d         = dlo_q;
    xor_d         = xor_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = cmd_valid_q && !frm_if.cmd_ready;
    err_chk_d     = 1'b0;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    if (frm_if.rx_err) begin
      state_d     = ST_HUNT;
      err_frame_d = 1'b1;
    end else if (frm_if.rx_done) begin
      case (state_q)
        ST_HUNT: if (frm_if.rx_data == SYNC_BYTE) state_d = ST_OP;
        ST_OP: begin
          op_d    = frm_if.rx_data;
          xor_d   = frm_if.rx_data;
          state_d = ST_ADDR;
        end
        ST_ADDR: begin
          addr_d  = frm_if.rx_data;
          xor_d   = xor_q ^ frm_if.rx_data;
          state_d = ST_DHI;
        end
        ST_DHI: begin
          dhi_d   = frm_if.rx_data;
          xor_d   = xor_q ^ frm_if.rx_data;
          state_d = ST_DLO;
        end
        ST_DLO: begin
          dlo_d   = frm_if.rx_data;
          xor_d   = xor_q ^ frm_if.rx_data;
          state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_HUNT;
          if (frm_if.rx_data != xor_q) begin
            err_chk_d = 1'b1;
          end else if (slot_free) begin
            cmd_d       = '{op: op_q, addr: addr_q, data: {dhi_q, dlo_q}};
            cmd_valid_d = 1'b1;
          end else begin
            err_overrun_d = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (expire) begin
      state_d       = ST_HUNT;
      err_timeout_d = 1'b1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frm_if.err_clr) begin
      err_cnt_d = '0;
    end else if ((err_chk_q || err_frame_q || err_timeout_q || err_overrun_q) &&
                 (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q       <= ST_HUNT;
      op_q          <= '0;
      addr_q        <= '0;
      dhi_q         <= '0;
      dlo_q         <= '0;
      xor_q         <= '0;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      err_chk_q     <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      dhi_q         <= dhi_d;
      dlo_q         <= dlo_d;
      xor_q         <= xor_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      err_chk_q     <= err_chk_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign frm_if.cmd_valid   = cmd_valid_q;
  assign frm_if.cmd_op      = cmd_q.op;
  assign frm_if.cmd_addr    = cmd_q.addr;
  assign frm_if.cmd_data    = cmd_q.data;
  assign frm_if.err_chk     = err_chk_q;
  assign frm_if.err_frame   = err_frame_q;
  assign frm_if.err_timeout = err_timeout_q;
  assign frm_if.err_overrun = err_overrun_q;
  assign frm_if.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - directed and randomized bench for uart_frame_ctrl against a frame-level model
module tb_uart_frame_ctrl;
  import uart_frame_pkg::*;

  localparam int CLK_HZ        = 1000;
  localparam int BAUD          = 100;
  localparam int TIMEOUT_BYTES = 1;
  localparam int T             = CLK_HZ / BAUD * 10 * TIMEOUT_BYTES;

  logic clk   = 1'b0;
  logic anrst = 1'b0;
  always #5 clk = ~clk;

  uart_frame_ctrl_if bus_if ();

  uart_frame_ctrl #(
    .CLK_HZ        (CLK_HZ),
    .BAUD          (BAUD),
    .TIMEOUT_BYTES (TIMEOUT_BYTES)
  ) dut (
    .clk    (clk),
    .anrst  (anrst),
    .frm_if (bus_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame-level reference: bytes after a sync are queued until a frame is complete.
  logic [7:0] frame_q[$];
  cmd_t       exp_q[$];
  bit         hunting   = 1'b1;
  int         last_edge = 0;
  int         cyc       = 0;
  int         m_chk = 0, m_frame = 0, m_to = 0, m_ovr = 0, m_cnt = 0;
  int         o_chk = 0, o_frame = 0, o_to = 0, o_ovr = 0;

  function automatic void model_err();
    if (m_cnt < 255) m_cnt++;
  endfunction

  function automatic void model_advance(input int e);
    if (!hunting && (e - last_edge > T)) begin
      m_to++;
      model_err();
      hunting = 1'b1;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int e);
    cmd_t c;
    logic [7:0] x;
    last_edge = e;
    if (hunting) begin
      if (b == 8'hA5) begin
        hunting = 1'b0;
        frame_q.delete();
      end
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == FRAME_LEN - 1) begin
        hunting = 1'b1;
        x = frame_q[0] ^ frame_q[1] ^ frame_q[2] ^ frame_q[3];
        if (x != frame_q[4]) begin
          m_chk++;
          model_err();
        end else if (!bus_if.cmd_ready && exp_q.size() > 0) begin
          m_ovr++;
          model_err();
        end else begin
          c.op   = frame_q[0];
          c.addr = frame_q[1];
          c.data = {frame_q[2], frame_q[3]};
          exp_q.push_back(c);
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pulse(input logic [7:0] b, input int gap, input bit done, input bit err);
    repeat (gap) step();
    bus_if.rx_data = b;
    bus_if.rx_done = done;
    bus_if.rx_err  = err;
    step();
    bus_if.rx_done = 1'b0;
    bus_if.rx_err  = 1'b0;
    model_advance(cyc);
    if (err) begin
      m_frame++;
      model_err();
      hunting = 1'b1;
    end else if (done) begin
      model_byte(b, cyc);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    pulse(b, gap, 1'b1, 1'b0);
  endtask

  function automatic int rgap(input bit rnd);
    int r;
    if (!rnd) return 0;
    r = $urandom_range(0, 15);
    if (r == 0) return T - 1 + $urandom_range(0, 2);
    return $urandom_range(0, 2);
  endfunction

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] dhi,
                            input logic [7:0] dlo, input logic [7:0] chk_flip, input bit rnd);
    send(8'hA5, rgap(rnd));
    send(op, rgap(rnd));
    send(addr, rgap(rnd));
    send(dhi, rgap(rnd));
    send(dlo, rgap(rnd));
    send(op ^ addr ^ dhi ^ dlo ^ chk_flip, rgap(rnd));
  endtask

  task automatic settle(input string tag, input int pending);
    repeat (T + 3) step();
    model_advance(cyc);
    check({tag, "_chk"}, 32'(o_chk), 32'(m_chk));
    check({tag, "_frame"}, 32'(o_frame), 32'(m_frame));
    check({tag, "_timeout"}, 32'(o_to), 32'(m_to));
    check({tag, "_overrun"}, 32'(o_ovr), 32'(m_ovr));
    check({tag, "_errcnt"}, 32'(bus_if.err_cnt), 32'(m_cnt));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'(pending));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus_if.cmd_valid), 32'd0);
    check({tag, "_cmd"}, {bus_if.cmd_op, bus_if.cmd_addr, bus_if.cmd_data}, 32'd0);
    check({tag, "_errcnt"}, 32'(bus_if.err_cnt), 32'd0);
    check({tag, "_strobes"}, 32'({bus_if.err_chk, bus_if.err_frame, bus_if.err_timeout,
                                  bus_if.err_overrun}), 32'd0);
  endtask

  cmd_t held;
  bit   held_v = 1'b0;
  cmd_t mon_exp;

  always @(negedge clk) begin
    if (!anrst) begin
      held_v = 1'b0;
    end else begin
      if (bus_if.err_chk)     o_chk++;
      if (bus_if.err_frame)   o_frame++;
      if (bus_if.err_timeout) o_to++;
      if (bus_if.err_overrun) o_ovr++;
      if (bus_if.cmd_valid) begin
        if (held_v) check("cmd_stable", {bus_if.cmd_op, bus_if.cmd_addr, bus_if.cmd_data}, held);
        if (bus_if.cmd_ready) begin
          check("cmd_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("cmd_fields", {bus_if.cmd_op, bus_if.cmd_addr, bus_if.cmd_data}, mon_exp);
          end
          held_v = 1'b0;
        end else begin
          held   = {bus_if.cmd_op, bus_if.cmd_addr, bus_if.cmd_data};
          held_v = 1'b1;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_if.rx_data   = '0;
    bus_if.rx_done   = 1'b0;
    bus_if.rx_err    = 1'b0;
    bus_if.cmd_ready = 1'b1;
    bus_if.err_clr   = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    anrst = 1'b1;
    step();

    // Basic accepted frame and its latency.
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h00, 1'b0);
    check("lat_valid", 32'(bus_if.cmd_valid), 32'd1);
    step();
    check("valid_one_cycle", 32'(bus_if.cmd_valid), 32'd0);
    settle("t1", 0);

    // Bad checksum, garbage, then a good frame.
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h01, 1'b0);
    check("chk_pulse", 32'({bus_if.err_chk, bus_if.cmd_valid}), 32'b10);
    send(8'h00, 0);
    check("chk_one_cycle", 32'(bus_if.err_chk), 32'd0);
    send(8'hFF, 0);
    send_frame(8'h7E, 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0);
    settle("t2", 0);

    bus_if.err_clr = 1'b1;
    step();
    bus_if.err_clr = 1'b0;
    m_cnt = 0;
    check("clr", 32'(bus_if.err_cnt), 32'd0);

    // Overrun while a command is held.
    bus_if.cmd_ready = 1'b0;
    send_frame(8'h02, 8'h20, 8'hAB, 8'hCD, 8'h00, 1'b0);
    send_frame(8'h03, 8'h30, 8'h55, 8'h66, 8'h00, 1'b0);
    check("ovr_pulse", 32'(bus_if.err_overrun), 32'd1);
    settle("t3", 1);
    check("held_fields", {bus_if.cmd_op, bus_if.cmd_addr, bus_if.cmd_data}, 32'h0220ABCD);
    bus_if.cmd_ready = 1'b1;
    step();
    step();
    check("after_xfer", 32'(bus_if.cmd_valid), 32'd0);
    settle("t3x", 0);

    // Timeout, then a byte landing exactly on the terminal cycle.
    send(8'hA5, 0);
    send(8'h01, 0);
    repeat (T - 1) step();
    check("to_early", 32'(bus_if.err_timeout), 32'd0);
    step();
    check("to_pulse", 32'(bus_if.err_timeout), 32'd1);
    step();
    check("to_one_cycle", 32'(bus_if.err_timeout), 32'd0);
    send_frame(8'h04, 8'h40, 8'h9A, 8'hBC, 8'h00, 1'b0);
    settle("t4", 0);
    send(8'hA5, 0);
    send(8'h05, 0);
    send(8'h50, T - 1);
    send(8'h11, 0);
    send(8'h22, T - 1);
    send(8'h05 ^ 8'h50 ^ 8'h11 ^ 8'h22, 0);
    settle("t4b", 0);

    // Line error mid-frame; the tail of the broken frame is ignored.
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h10, 0);
    pulse(8'h12, 0, 1'b1, 1'b1);
    check("frame_pulse", 32'(bus_if.err_frame), 32'd1);
    send(8'h34, 0);
    send(8'h37, 0);
    send_frame(8'h06, 8'h60, 8'h01, 8'h02, 8'h00, 1'b0);
    settle("t5", 0);

    for (int i = 0; i < 300; i++) pulse(8'h00, 0, 1'b0, 1'b1);
    settle("sat", 0);
    pulse(8'h00, 0, 1'b0, 1'b1);
    bus_if.err_clr = 1'b1;
    step();
    bus_if.err_clr = 1'b0;
    m_cnt = 0;
    step();
    check("clr_wins", 32'(bus_if.err_cnt), 32'd0);

    // Asynchronous reset in DHI with a command held.
    bus_if.cmd_ready = 1'b0;
    send_frame(8'h08, 8'h80, 8'h11, 8'h22, 8'h00, 1'b0);
    send(8'hA5, 0);
    send(8'h09, 0);
    send(8'h90, 0);
    #2;
    anrst = 1'b0;
    #1;
    check_reset_outputs("arst");
    exp_q.delete();
    hunting = 1'b1;
    m_cnt = 0;
    step();
    step();
    anrst = 1'b1;
    bus_if.cmd_ready = 1'b1;
    send_frame(8'h0A, 8'hA0, 8'h33, 8'h44, 8'h00, 1'b0);
    settle("t6", 0);

    // Randomized mix of good, corrupt, partial and garbage traffic.
    for (int f = 0; f < 60; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h00, 1'b1);
      end else if (kind <= 7) begin
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom_range(1, 255)), 1'b1);
      end else if (kind == 8) begin
        for (int k = 0; k < 3; k++) send(8'($urandom), rgap(1'b1));
      end else begin
        send(8'hA5, rgap(1'b1));
        for (int k = 0; k < int'($urandom_range(0, 4)); k++) send(8'($urandom), rgap(1'b1));
        pulse(8'($urandom), rgap(1'b1), 1'($urandom_range(0, 1)), 1'b1);
      end
    end
    settle("rnd", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
